// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: sequences the Sobel line-buffer shift enable and flags complete 3x3 windows
module sobel_window_ctrl #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int COL_W      = $clog2(IMG_WIDTH),
   parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             Start,
   input  logic             PixelValid,
   output logic             PixelReady,
   output logic             ShiftEnable,
   output logic             WindowValid,
   output logic [ROW_W-1:0] WinRow,
   output logic [COL_W-1:0] WinCol,
   output logic             Busy,
   output logic             FrameDone
);
   typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;
   state_t           state_q, state_d;
   logic [COL_W-1:0] col_q, col_d, win_col_q, win_col_d;
   logic [ROW_W-1:0] row_q, row_d, win_row_q, win_row_d;
   logic             win_valid_q, win_valid_d, frame_done_q, frame_done_d;
   logic             acc, col_last, row_last, win_hit;
   assign PixelReady  = (state_q == FILL) || (state_q == STREAM);
   assign acc         = PixelValid & PixelReady;
   assign ShiftEnable = acc;
   assign Busy        = state_q != IDLE;
   assign col_last    = col_q == COL_W'(IMG_WIDTH - 1);
   assign row_last    = row_q == ROW_W'(IMG_HEIGHT - 1);
   // a window is complete once two full rows and two columns of the current row are in the chain
   assign win_hit     = acc && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
   assign WindowValid = win_valid_q;
   assign WinRow      = win_row_q;
   assign WinCol      = win_col_q;
   assign FrameDone   = frame_done_q;
   // next state, raster counters and window flag
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      frame_done_d = 1'b0;
      win_valid_d  = win_hit;
      win_row_d    = win_hit ? row_q - ROW_W'(1) : win_row_q;
      win_col_d    = win_hit ? col_q - COL_W'(1) : win_col_q;
      case (state_q)
         IDLE: if (Start) begin
            state_d = FILL;
            col_d   = '0;
            row_d   = '0;
         end
         FILL: if (acc && col_last && row_q == ROW_W'(1)) state_d = STREAM;
         STREAM: if (acc && col_last && row_last) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (acc) begin
         col_d = col_last ? '0 : col_q + COL_W'(1);
         row_d = col_last ? (row_last ? '0 : row_q + ROW_W'(1)) : row_q;
      end
   end
   // state and output registers, cleared asynchronously so a partial frame is dropped
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q      <= IDLE;
         col_q        <= '0;
         row_q        <= '0;
         win_valid_q  <= 1'b0;
         win_row_q    <= '0;
         win_col_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         win_valid_q  <= win_valid_d;
         win_row_q    <= win_row_d;
         win_col_q    <= win_col_d;
         frame_done_q <= frame_done_d;
      end
   end
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb_sobel_window_ctrl: scoreboard bench for the Sobel window controller
module tb_sobel_window_ctrl;
   localparam int W = 5;
   localparam int H = 4;
   logic       clk, rst_n;
   logic       start, pv, ready, se, wv, busy, fd;
   logic [1:0] wr;
   logic [2:0] wc;
   logic       b_start, b_pv, b_ready, b_se, b_wv, b_busy, b_fd;
   logic [1:0] b_wr, b_wc;
   int         checks, errors, m_phase, m_n, m_wins, frames;
   logic       m_wv, m_fd;
   logic [15:0] exp_q[$];
   logic [15:0] e;

   sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .CLK(clk), .RST_n(rst_n), .Start(start), .PixelValid(pv), .PixelReady(ready),
      .ShiftEnable(se), .WindowValid(wv), .WinRow(wr), .WinCol(wc), .Busy(busy), .FrameDone(fd));

   sobel_window_ctrl #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) dut_b (
      .CLK(clk), .RST_n(rst_n), .Start(b_start), .PixelValid(b_pv), .PixelReady(b_ready),
      .ShiftEnable(b_se), .WindowValid(b_wv), .WinRow(b_wr), .WinCol(b_wc), .Busy(b_busy), .FrameDone(b_fd));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc(input logic s, input logic v);
      start = s;
      pv    = v;
      @(posedge clk);
      #1;
   endtask

   // reference model: evaluated mid-cycle, predicts the next edge from the stable inputs
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_ready", ready, 0);
         chk("rst_shift", se, 0);
         chk("rst_busy", busy, 0);
         chk("rst_wv", wv, 0);
         chk("rst_wr", wr, 0);
         chk("rst_wc", wc, 0);
         chk("rst_fd", fd, 0);
         m_phase = 0;
         m_n     = 0;
         m_wv    = 0;
         m_fd    = 0;
         m_wins  = 0;
         exp_q.delete();
      end else begin
         chk("ready", ready, int'(m_phase == 1));
         chk("shift", se, int'(pv && m_phase == 1));
         chk("busy", busy, int'(m_phase != 0));
         chk("frame_done", fd, m_fd);
         chk("win_valid", wv, m_wv);
         if (wv && m_wv) begin
            e = exp_q.pop_front();
            chk("win_row", wr, e[15:8]);
            chk("win_col", wc, e[7:0]);
            m_wins++;
         end
         if (m_fd) begin
            chk("win_count", m_wins, (W - 2) * (H - 2));
            chk("q_empty", exp_q.size(), 0);
            frames++;
            m_wins = 0;
         end
         m_wv = 0;
         m_fd = 0;
         case (m_phase)
            0: if (start) begin
               m_phase = 1;
               m_n     = 0;
            end
            1: if (pv) begin
               if (m_n / W >= 2 && m_n % W >= 2) begin
                  exp_q.push_back({8'(m_n / W - 1), 8'(m_n % W - 1)});
                  m_wv = 1;
               end
               m_n++;
               if (m_n == W * H) begin
                  m_phase = 2;
                  m_fd    = 1;
               end
            end
            default: m_phase = 0;
         endcase
      end
   end

   initial begin
      checks = 0; errors = 0; frames = 0;
      m_phase = 0; m_n = 0; m_wins = 0; m_wv = 0; m_fd = 0;
      rst_n = 0; start = 0; pv = 0; b_start = 0; b_pv = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      // idle with valid but no start
      repeat (3) cyc(0, 1);
      // back-to-back frame, then start coinciding with the done cycle
      cyc(1, 0);
      repeat (20) cyc(0, 1);
      cyc(1, 0);
      repeat (3) cyc(0, 0);
      // valid toggling every cycle
      cyc(1, 0);
      for (int i = 0; i < 40; i++) cyc(0, i % 2 == 0);
      repeat (3) cyc(0, 0);
      // start pulsed mid-frame
      cyc(1, 0);
      repeat (7) cyc(0, 1);
      cyc(1, 1);
      repeat (12) cyc(0, 1);
      repeat (3) cyc(0, 0);
      // asynchronous reset mid-frame, then a fresh frame
      cyc(1, 0);
      repeat (15) cyc(0, 1);
      #2 rst_n = 0;
      #1;
      chk("async_ready", ready, 0);
      chk("async_shift", se, 0);
      chk("async_busy", busy, 0);
      chk("async_wv", wv, 0);
      chk("async_wr", wr, 0);
      chk("async_wc", wc, 0);
      pv = 0;
      @(posedge clk);
      #1 rst_n = 1;
      cyc(1, 0);
      repeat (20) cyc(0, 1);
      repeat (3) cyc(0, 0);
      chk("frames", frames, 4);
      chk("q_final", exp_q.size(), 0);
      // 3x3 image: single window after the ninth pixel
      b_start = 1;
      @(posedge clk);
      #1 b_start = 0;
      b_pv = 1;
      for (int i = 0; i < 9; i++) begin
         #3;
         chk("b_shift", b_se, 1);
         chk("b_wv_early", b_wv, 0);
         @(posedge clk);
         #1;
      end
      b_pv = 0;
      chk("b_wv", b_wv, 1);
      chk("b_wr", b_wr, 1);
      chk("b_wc", b_wc, 1);
      chk("b_fd", b_fd, 1);
      @(posedge clk);
      #1;
      chk("b_wv_after", b_wv, 0);
      chk("b_fd_after", b_fd, 0);
      chk("b_busy_after", b_busy, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
